// File: rtl/spine_route_engine_pkg.sv
// Shared definitions for the spine routing stage: route decision kinds,
// the drop port code, the group->port map and destination field helpers.
package spine_route_engine_pkg;

    localparam int PORT_DROP = 0;

    typedef enum logic [1:0] {
        DEC_DROP   = 2'd0,
        DEC_LOCAL  = 2'd1,
        DEC_DIRECT = 2'd2,
        DEC_DETOUR = 2'd3
    } route_dec_e;

    // Remote groups occupy the ports after the leaves, numbered by rank with
    // this spine's own group squeezed out of the sequence.
    function automatic int spine_port(input int group, input int self_id, input int num_leaves);
        if (group < self_id) begin
            return num_leaves + group;
        end
        return num_leaves + group - 1;
    endfunction

    function automatic logic [31:0] dest_group(input logic [31:0] dest, input int leaf_w);
        return dest >> leaf_w;
    endfunction

    function automatic logic [31:0] dest_leaf(input logic [31:0] dest, input int leaf_w);
        return dest & ((32'd1 << leaf_w) - 32'd1);
    endfunction

endpackage

// File: rtl/spine_route_engine_if.sv
// Request/response bundle of the spine routing stage, plus link health and
// the statistics counters that travel with it.
interface spine_route_engine_if #(
    parameter int NUM_GROUPS = 8,
    parameter int GROUP_W    = 4,
    parameter int LEAF_W     = 2,
    parameter int PORT_W     = 4,
    parameter int CNT_W      = 16
) ();

    logic                        req_valid;
    logic                        req_ready;
    logic [GROUP_W+LEAF_W-1:0]   req_dest;
    logic [NUM_GROUPS-1:0]       link_up;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [PORT_W-1:0]           rsp_port;
    logic                        rsp_drop;
    logic                        rsp_detour;
    logic [CNT_W-1:0]            drop_cnt;
    logic [CNT_W-1:0]            detour_cnt;

    modport master (
        output req_valid, req_dest, link_up, rsp_ready,
        input  req_ready, rsp_valid, rsp_port, rsp_drop, rsp_detour, drop_cnt, detour_cnt
    );

    modport slave (
        input  req_valid, req_dest, link_up, rsp_ready,
        output req_ready, rsp_valid, rsp_port, rsp_drop, rsp_detour, drop_cnt, detour_cnt
    );

endinterface

// File: rtl/spine_route_engine_rr_pick.sv
// Round-robin alternate spine selector: finds the first live group, other
// than this spine and the original destination, at or after rr_ptr, wrapping.
module spine_rr_pick #(
    parameter int NUM_GROUPS = 8,
    parameter int GROUP_ID   = 2,
    parameter int GROUP_W    = 4
) (
    input  logic [NUM_GROUPS-1:0] i_link_up,
    input  logic [GROUP_W-1:0]    i_dest_group,
    input  logic [GROUP_W-1:0]    i_rr_ptr,
    output logic                  o_found,
    output logic [GROUP_W-1:0]    o_group
);

    logic [NUM_GROUPS-1:0] w_elig;

    // Candidate mask: live links, excluding our own group and the dead destination.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            w_elig[i] = i_link_up[i] && ((i + 1) != GROUP_ID) && ((i + 1) != int'(i_dest_group));
        end
    end

    // Two passes give the cyclic scan: groups >= rr_ptr first, then the wrapped low groups.
    always_comb begin
        o_found = 1'b0;
        o_group = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            if (!o_found && w_elig[i] && ((i + 1) >= int'(i_rr_ptr))) begin
                o_found = 1'b1;
                o_group = GROUP_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_GROUPS; i++) begin
            if (!o_found && w_elig[i] && ((i + 1) < int'(i_rr_ptr))) begin
                o_found = 1'b1;
                o_group = GROUP_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/spine_route_engine.sv
// Registered spine routing stage: decodes {group, leaf} into a crossbar port,
// detours around dead inter-group links round-robin, and counts drops/detours.
module spine_route_engine
    import spine_route_engine_pkg::*;
#(
    parameter int GROUP_ID   = 2,
    parameter int NUM_GROUPS = 8,
    parameter int NUM_LEAVES = 4,
    parameter int GROUP_W    = 4,
    parameter int LEAF_W     = 2,
    parameter int PORT_W     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spine_route_engine_if.slave  bus
);

    logic [GROUP_W-1:0] w_group;
    logic [LEAF_W-1:0]  w_leaf;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_rsp_fire;
    logic               w_dest_live;
    logic               w_pick_found;
    logic [GROUP_W-1:0] w_pick_group;
    logic [GROUP_W-1:0] w_rr_next;
    route_dec_e         w_dec;
    logic [PORT_W-1:0]  w_port;

    logic [GROUP_W-1:0] r_rr_ptr;
    logic               r_rsp_valid;
    logic [PORT_W-1:0]  r_rsp_port;
    logic               r_rsp_drop;
    logic               r_rsp_detour;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   r_detour_cnt;

    assign w_group     = GROUP_W'(dest_group(32'(bus.req_dest), LEAF_W));
    assign w_leaf      = LEAF_W'(dest_leaf(32'(bus.req_dest), LEAF_W));
    assign w_req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;
    assign w_rr_next   = (int'(w_pick_group) >= NUM_GROUPS) ? GROUP_W'(1) : w_pick_group + GROUP_W'(1);

    spine_rr_pick #(
        .NUM_GROUPS (NUM_GROUPS),
        .GROUP_ID   (GROUP_ID),
        .GROUP_W    (GROUP_W)
    ) u_rr_pick (
        .i_link_up    (bus.link_up),
        .i_dest_group (w_group),
        .i_rr_ptr     (r_rr_ptr),
        .o_found      (w_pick_found),
        .o_group      (w_pick_group)
    );

    // Health of the direct spine link toward the destination group.
    always_comb begin
        w_dest_live = 1'b0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            if ((i + 1) == int'(w_group)) begin
                w_dest_live = bus.link_up[i];
            end
        end
    end

    // Route decision in priority order: invalid group, local leaf, direct link, detour, drop.
    always_comb begin
        w_dec = DEC_DROP;
        if (w_group == '0 || int'(w_group) > NUM_GROUPS) begin
            w_dec = DEC_DROP;
        end else if (int'(w_group) == GROUP_ID) begin
            w_dec = (int'(w_leaf) < NUM_LEAVES) ? DEC_LOCAL : DEC_DROP;
        end else if (w_dest_live) begin
            w_dec = DEC_DIRECT;
        end else if (w_pick_found) begin
            w_dec = DEC_DETOUR;
        end
    end

    // Port number for the chosen decision.
    always_comb begin
        w_port = PORT_W'(PORT_DROP);
        case (w_dec)
            DEC_LOCAL:  w_port = PORT_W'(int'(w_leaf) + 1);
            DEC_DIRECT: w_port = PORT_W'(spine_port(int'(w_group), GROUP_ID, NUM_LEAVES));
            DEC_DETOUR: w_port = PORT_W'(spine_port(int'(w_pick_group), GROUP_ID, NUM_LEAVES));
            default:    w_port = PORT_W'(PORT_DROP);
        endcase
    end

    // Output stage: load on accept, clear valid once consumed, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_port   <= '0;
            r_rsp_drop   <= 1'b0;
            r_rsp_detour <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_port   <= w_port;
            r_rsp_drop   <= (w_dec == DEC_DROP);
            r_rsp_detour <= (w_dec == DEC_DETOUR);
        end else if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    // Round-robin pointer moves past the chosen alternate only on accepted detours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= GROUP_W'(1);
        end else if (w_accept && (w_dec == DEC_DETOUR)) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Saturating statistics, counted when a response is actually handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt   <= '0;
            r_detour_cnt <= '0;
        end else begin
            if (w_rsp_fire && r_rsp_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_rsp_fire && r_rsp_detour && (r_detour_cnt != '1)) begin
                r_detour_cnt <= r_detour_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_port   = r_rsp_port;
    assign bus.rsp_drop   = r_rsp_drop;
    assign bus.rsp_detour = r_rsp_detour;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.detour_cnt = r_detour_cnt;

endmodule

// File: tb/tb_spine_route_engine.sv
// Directed bench for spine_route_engine with the default G2 / 8-group configuration.
module tb_spine_route_engine;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    spine_route_engine_if #(.NUM_GROUPS(8), .GROUP_W(4), .LEAF_W(2), .PORT_W(4), .CNT_W(16)) bus ();

    spine_route_engine #(
        .GROUP_ID(2), .NUM_GROUPS(8), .NUM_LEAVES(4),
        .GROUP_W(4), .LEAF_W(2), .PORT_W(4), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_dest  = '0;
        bus.rsp_ready = 1'b1;
        bus.link_up   = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one request for one cycle; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] g, input logic [1:0] l, input logic [7:0] link);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_dest  = {g, l};
        bus.link_up   = link;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL reset_valid: got %0d expected 0", bus.rsp_valid); n_fail++; end n_checks++;
        if (bus.rsp_port !== 4'd0) begin $display("FAIL reset_port: got %0d expected 0", bus.rsp_port); n_fail++; end n_checks++;
        if (bus.rsp_drop !== 1'b0) begin $display("FAIL reset_drop: got %0d expected 0", bus.rsp_drop); n_fail++; end n_checks++;
        if (bus.rsp_detour !== 1'b0) begin $display("FAIL reset_detour: got %0d expected 0", bus.rsp_detour); n_fail++; end n_checks++;
        if (bus.drop_cnt !== 16'd0) begin $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); n_fail++; end n_checks++;
        if (bus.detour_cnt !== 16'd0) begin $display("FAIL reset_detour_cnt: got %0d expected 0", bus.detour_cnt); n_fail++; end n_checks++;
        if (bus.req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %0d expected 1", bus.req_ready); n_fail++; end n_checks++;
    endtask

    task automatic test_local();
        logic [3:0] exp_port;
        do_reset();
        // Before the first accepting edge no response may be visible.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_dest  = {4'd2, 2'd0};
        #1;
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL local_latency_pre: got %0d expected 0", bus.rsp_valid); n_fail++; end n_checks++;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (bus.rsp_valid !== 1'b1) begin $display("FAIL local_latency_post: got %0d expected 1", bus.rsp_valid); n_fail++; end n_checks++;
        if (bus.rsp_port !== 4'd1) begin $display("FAIL local_port_leaf0: got %0d expected 1", bus.rsp_port); n_fail++; end n_checks++;
        for (int l = 1; l < 4; l++) begin
            exp_port = 4'(l + 1);
            issue(4'd2, 2'(l), 8'hFF);
            if (bus.rsp_valid !== 1'b1) begin $display("FAIL local_valid leaf %0d: got %0d expected 1", l, bus.rsp_valid); n_fail++; end n_checks++;
            if (bus.rsp_port !== exp_port) begin $display("FAIL local_port leaf %0d: got %0d expected %0d", l, bus.rsp_port, exp_port); n_fail++; end n_checks++;
            if ({bus.rsp_drop, bus.rsp_detour} !== 2'b00) begin $display("FAIL local_flags leaf %0d: got %b expected 00", l, {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] grp [7];
        logic [3:0] exp [7];
        grp = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        exp = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue(grp[i], 2'd0, 8'hFF);
            if (bus.rsp_valid !== 1'b1) begin $display("FAIL b2b_valid g%0d: got %0d expected 1", grp[i], bus.rsp_valid); n_fail++; end n_checks++;
            if (bus.rsp_port !== exp[i]) begin $display("FAIL b2b_port g%0d: got %0d expected %0d", grp[i], bus.rsp_port, exp[i]); n_fail++; end n_checks++;
            if ({bus.rsp_drop, bus.rsp_detour} !== 2'b00) begin $display("FAIL b2b_flags g%0d: got %b expected 00", grp[i], {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
            if (bus.req_ready !== 1'b1) begin $display("FAIL b2b_req_ready g%0d: got %0d expected 1", grp[i], bus.req_ready); n_fail++; end n_checks++;
        end
        idle(1);
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL b2b_drain: got %0d expected 0", bus.rsp_valid); n_fail++; end n_checks++;
        if (bus.detour_cnt !== 16'd0 || bus.drop_cnt !== 16'd0) begin $display("FAIL b2b_counts: got %0d/%0d expected 0/0", bus.drop_cnt, bus.detour_cnt); n_fail++; end n_checks++;
    endtask

    task automatic test_detour();
        do_reset();
        issue(4'd3, 2'd0, 8'hFB);
        if (bus.rsp_port !== 4'd5) begin $display("FAIL detour1_port: got %0d expected 5", bus.rsp_port); n_fail++; end n_checks++;
        if ({bus.rsp_drop, bus.rsp_detour} !== 2'b01) begin $display("FAIL detour1_flags: got %b expected 01", {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        issue(4'd3, 2'd1, 8'hFB);
        if (bus.rsp_port !== 4'd7) begin $display("FAIL detour2_port: got %0d expected 7", bus.rsp_port); n_fail++; end n_checks++;
        if ({bus.rsp_drop, bus.rsp_detour} !== 2'b01) begin $display("FAIL detour2_flags: got %b expected 01", {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        idle(1);
        if (bus.detour_cnt !== 16'd2) begin $display("FAIL detour_cnt: got %0d expected 2", bus.detour_cnt); n_fail++; end n_checks++;
        if (bus.drop_cnt !== 16'd0) begin $display("FAIL detour_drop_cnt: got %0d expected 0", bus.drop_cnt); n_fail++; end n_checks++;
    endtask

    task automatic test_no_alternate();
        do_reset();
        issue(4'd3, 2'd0, 8'h10);
        if (bus.rsp_port !== 4'd8) begin $display("FAIL only_g5_port: got %0d expected 8", bus.rsp_port); n_fail++; end n_checks++;
        if ({bus.rsp_drop, bus.rsp_detour} !== 2'b01) begin $display("FAIL only_g5_flags: got %b expected 01", {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        issue(4'd3, 2'd0, 8'h00);
        if (bus.rsp_port !== 4'd0) begin $display("FAIL all_down_port: got %0d expected 0", bus.rsp_port); n_fail++; end n_checks++;
        if ({bus.rsp_drop, bus.rsp_detour} !== 2'b10) begin $display("FAIL all_down_flags: got %b expected 10", {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        idle(1);
        if (bus.drop_cnt !== 16'd1) begin $display("FAIL all_down_drop_cnt: got %0d expected 1", bus.drop_cnt); n_fail++; end n_checks++;
        if (bus.detour_cnt !== 16'd1) begin $display("FAIL all_down_detour_cnt: got %0d expected 1", bus.detour_cnt); n_fail++; end n_checks++;
    endtask

    task automatic test_bad_group();
        logic [3:0] bad [3];
        bad = '{4'd0, 4'd9, 4'd15};
        do_reset();
        // Move rr_ptr to 2 first so an erroneous update by a drop becomes visible.
        issue(4'd3, 2'd0, 8'hFB);
        if (bus.rsp_port !== 4'd5) begin $display("FAIL bad_pre_port: got %0d expected 5", bus.rsp_port); n_fail++; end n_checks++;
        for (int i = 0; i < 3; i++) begin
            issue(bad[i], 2'd3, 8'hFB);
            if (bus.rsp_port !== 4'd0) begin $display("FAIL bad_port g%0d: got %0d expected 0", bad[i], bus.rsp_port); n_fail++; end n_checks++;
            if ({bus.rsp_valid, bus.rsp_drop, bus.rsp_detour} !== 3'b110) begin $display("FAIL bad_flags g%0d: got %b expected 110", bad[i], {bus.rsp_valid, bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        end
        issue(4'd3, 2'd0, 8'hFB);
        if (bus.rsp_port !== 4'd7) begin $display("FAIL bad_rr_kept: got %0d expected 7", bus.rsp_port); n_fail++; end n_checks++;
        idle(1);
        if (bus.drop_cnt !== 16'd3) begin $display("FAIL bad_drop_cnt: got %0d expected 3", bus.drop_cnt); n_fail++; end n_checks++;
        if (bus.detour_cnt !== 16'd2) begin $display("FAIL bad_detour_cnt: got %0d expected 2", bus.detour_cnt); n_fail++; end n_checks++;
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        issue(4'd3, 2'd0, 8'hFB);
        if ({bus.rsp_valid, bus.rsp_detour} !== 2'b11 || bus.rsp_port !== 4'd5) begin $display("FAIL hold_first: got v/d %b port %0d expected 11 port 5", {bus.rsp_valid, bus.rsp_detour}, bus.rsp_port); n_fail++; end n_checks++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_dest  = {4'd1, 2'd0};
            bus.link_up   = (c % 2 == 0) ? 8'h00 : 8'hFF;
            #1;
            if (bus.req_ready !== 1'b0) begin $display("FAIL hold_req_ready cyc %0d: got %0d expected 0", c, bus.req_ready); n_fail++; end n_checks++;
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 4'd5) begin $display("FAIL hold_stable cyc %0d: got valid %0d port %0d expected 1 port 5", c, bus.rsp_valid, bus.rsp_port); n_fail++; end n_checks++;
            if ({bus.rsp_drop, bus.rsp_detour} !== 2'b01) begin $display("FAIL hold_flags cyc %0d: got %b expected 01", c, {bus.rsp_drop, bus.rsp_detour}); n_fail++; end n_checks++;
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL hold_rst_valid: got %0d expected 0", bus.rsp_valid); n_fail++; end n_checks++;
        if (bus.rsp_port !== 4'd0) begin $display("FAIL hold_rst_port: got %0d expected 0", bus.rsp_port); n_fail++; end n_checks++;
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        idle(3);
        if (bus.rsp_valid !== 1'b0) begin $display("FAIL hold_no_replay: got %0d expected 0", bus.rsp_valid); n_fail++; end n_checks++;
        if (bus.detour_cnt !== 16'd0) begin $display("FAIL hold_detour_cnt: got %0d expected 0", bus.detour_cnt); n_fail++; end n_checks++;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_dest  = '0;
        bus.rsp_ready = 1'b1;
        bus.link_up   = 8'hFF;
        test_reset();
        test_local();
        test_back_to_back();
        test_detour();
        test_no_alternate();
        test_bad_group();
        test_hold_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
